// File: rtl/ysyx_22050019_pkg.sv
// Shared IFU definitions: FSM encoding, boot PC and response codes.
package ysyx_22050019_pkg;

  typedef enum logic [2:0] {
    S_BOOT,
    S_REQ,
    S_WAIT,
    S_OUT,
    S_DROP
  } ifu_state_e;

  localparam logic [63:0] RESET_PC   = 64'h0000_0000_8000_0000;
  localparam int          INST_WIDTH = 32;
  localparam logic [1:0]  RESP_OKAY  = 2'b00;

endpackage

// File: rtl/ysyx_22050019_ifu.sv
// Instruction fetch unit: one outstanding icache request, a single-entry
// capture register toward the IDU, and redirect-safe response draining.
module ysyx_22050019_ifu #(
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 64,
  parameter int INST_WIDTH = ysyx_22050019_pkg::INST_WIDTH,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC = ysyx_22050019_pkg::RESET_PC
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  redirect_valid_i,
  input  logic [ADDR_WIDTH-1:0] redirect_pc_i,
  output logic                  ic_ar_valid_o,
  input  logic                  ic_ar_ready_i,
  output logic [ADDR_WIDTH-1:0] ic_ar_addr_o,
  input  logic                  ic_r_valid_i,
  output logic                  ic_r_ready_o,
  input  logic [1:0]            ic_r_resp_i,
  input  logic [DATA_WIDTH-1:0] ic_r_data_i,
  output logic                  id_valid_o,
  input  logic                  id_ready_i,
  output logic [ADDR_WIDTH-1:0] id_pc_o,
  output logic [INST_WIDTH-1:0] id_inst_o,
  output logic                  id_fault_o
);
  import ysyx_22050019_pkg::*;

  ifu_state_e state_q, state_d;

  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [ADDR_WIDTH-1:0] id_pc_q, id_pc_d;
  logic [INST_WIDTH-1:0] id_inst_q, id_inst_d;
  logic                  id_fault_q, id_fault_d;

  logic                  ar_hs, r_hs, id_hs;
  logic                  resp_err;
  logic [INST_WIDTH-1:0] word_inst;
  logic                  unused_redirect_lsb;

  assign ic_ar_valid_o = (state_q == S_REQ);
  assign ic_r_ready_o  = (state_q == S_WAIT)
                       | (state_q == S_DROP);
  // A redirect makes the held instruction wrong-path immediately.
  assign id_valid_o    = (state_q == S_OUT)
                       & ~redirect_valid_i;

  assign ar_hs = ic_ar_valid_o & ic_ar_ready_i;
  assign r_hs  = ic_r_ready_o & ic_r_valid_i;
  assign id_hs = id_valid_o & id_ready_i;

  assign resp_err  = (ic_r_resp_i != RESP_OKAY);
  assign word_inst = pc_q[2]
    ? ic_r_data_i[2*INST_WIDTH-1:INST_WIDTH]
    : ic_r_data_i[INST_WIDTH-1:0];

  assign unused_redirect_lsb = ^redirect_pc_i[1:0];

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    id_pc_d    = id_pc_q;
    id_inst_d  = id_inst_q;
    id_fault_d = id_fault_q;
    unique case (state_q)
      S_BOOT: state_d = S_REQ;
      S_REQ: begin
        if (ar_hs) begin
          state_d = redirect_valid_i ? S_DROP : S_WAIT;
        end
      end
      S_WAIT: begin
        if (redirect_valid_i) begin
          state_d = r_hs ? S_REQ : S_DROP;
        end else if (r_hs) begin
          id_pc_d    = pc_q;
          id_fault_d = resp_err;
          id_inst_d  = resp_err ? '0 : word_inst;
          state_d    = S_OUT;
        end
      end
      S_OUT: begin
        if (redirect_valid_i) begin
          state_d = S_REQ;
        end else if (id_hs) begin
          pc_d    = pc_q + ADDR_WIDTH'(4);
          state_d = S_REQ;
        end
      end
      S_DROP: begin
        if (r_hs) begin
          state_d = S_REQ;
        end
      end
      default: state_d = S_BOOT;
    endcase
    if (redirect_valid_i) begin
      pc_d = {redirect_pc_i[ADDR_WIDTH-1:2], 2'b00};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_BOOT;
      pc_q       <= RESET_PC;
      id_pc_q    <= '0;
      id_inst_q  <= '0;
      id_fault_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      id_pc_q    <= id_pc_d;
      id_inst_q  <= id_inst_d;
      id_fault_q <= id_fault_d;
    end
  end

  assign ic_ar_addr_o = pc_q;
  assign id_pc_o      = id_pc_q;
  assign id_inst_o    = id_inst_q;
  assign id_fault_o   = id_fault_q;

endmodule

// File: tb/tb_ysyx_22050019_ifu.sv
// Bench for ysyx_22050019_ifu: fetch table with an expected-result queue,
// plus reset sequences around the table.
module tb_ysyx_22050019_ifu;

  logic        clk;
  logic        rst;
  logic        redirect_valid_i;
  logic [63:0] redirect_pc_i;
  logic        ic_ar_valid_o;
  logic        ic_ar_ready_i;
  logic [63:0] ic_ar_addr_o;
  logic        ic_r_valid_i;
  logic        ic_r_ready_o;
  logic [1:0]  ic_r_resp_i;
  logic [63:0] ic_r_data_i;
  logic        id_valid_o;
  logic        id_ready_i;
  logic [63:0] id_pc_o;
  logic [31:0] id_inst_o;
  logic        id_fault_o;

  ysyx_22050019_ifu dut (
    .clk              (clk),
    .rst              (rst),
    .redirect_valid_i (redirect_valid_i),
    .redirect_pc_i    (redirect_pc_i),
    .ic_ar_valid_o    (ic_ar_valid_o),
    .ic_ar_ready_i    (ic_ar_ready_i),
    .ic_ar_addr_o     (ic_ar_addr_o),
    .ic_r_valid_i     (ic_r_valid_i),
    .ic_r_ready_o     (ic_r_ready_o),
    .ic_r_resp_i      (ic_r_resp_i),
    .ic_r_data_i      (ic_r_data_i),
    .id_valid_o       (id_valid_o),
    .id_ready_i       (id_ready_i),
    .id_pc_o          (id_pc_o),
    .id_inst_o        (id_inst_o),
    .id_fault_o       (id_fault_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef enum int {
    K_NORM,
    K_REDIR_AR,
    K_REDIR_WAIT,
    K_REDIR_OUT
  } kind_e;

  typedef struct {
    kind_e       kind;
    logic [63:0] addr;
    int          ar_stall;
    int          lat;
    logic [63:0] data;
    logic [1:0]  resp;
    logic [63:0] target;
    int          hold;
    logic [31:0] inst;
    logic        fault;
  } vec_t;

  typedef struct {
    logic [63:0] pc;
    logic [31:0] inst;
    logic        fault;
  } exp_t;

  localparam logic [63:0] BOOT_PC = 64'h0000_0000_8000_0000;

  exp_t sb[$];
  vec_t vecs[12];
  int   n_tests;
  int   n_fail;

  task automatic check(input string name,
                       input logic [63:0] act,
                       input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_ar(input logic [63:0] exp);
    int n = 0;
    while (ic_ar_valid_o !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("ar_valid_wait", 64'(ic_ar_valid_o), 64'd1);
    check("ar_addr", ic_ar_addr_o, exp);
  endtask

  task automatic consume(input int hold);
    exp_t        e;
    logic [63:0] pc0;
    logic [31:0] i0;
    int          n = 0;
    while (id_valid_o !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("id_valid_wait", 64'(id_valid_o), 64'd1);
    pc0 = id_pc_o;
    i0  = id_inst_o;
    for (int k = 0; k < hold; k++) begin
      @(negedge clk);
      check("hold_valid", 64'(id_valid_o), 64'd1);
      check("hold_pc", id_pc_o, pc0);
      check("hold_inst", 64'(id_inst_o), 64'(i0));
      check("hold_no_ar", 64'(ic_ar_valid_o), 64'd0);
    end
    if (sb.size() == 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL sb_underflow: got id pc %0h, expected nothing", id_pc_o);
    end else begin
      e = sb.pop_front();
      check("id_pc", id_pc_o, e.pc);
      check("id_inst", 64'(id_inst_o), 64'(e.inst));
      check("id_fault", 64'(id_fault_o), 64'(e.fault));
    end
    id_ready_i = 1'b1;
    @(negedge clk);
    id_ready_i = 1'b0;
    check("id_valid_drop", 64'(id_valid_o), 64'd0);
  endtask

  task automatic run_row(input vec_t v);
    exp_t        e;
    logic [63:0] tgt;
    tgt = {v.target[63:2], 2'b00};
    wait_ar(v.addr);
    for (int k = 0; k < v.ar_stall; k++) begin
      @(negedge clk);
      check("ar_stall_valid", 64'(ic_ar_valid_o), 64'd1);
      check("ar_stall_addr", ic_ar_addr_o, v.addr);
    end
    ic_ar_ready_i = 1'b1;
    if (v.kind == K_REDIR_AR) begin
      redirect_valid_i = 1'b1;
      redirect_pc_i    = v.target;
    end
    @(negedge clk);
    ic_ar_ready_i    = 1'b0;
    redirect_valid_i = 1'b0;
    check("ar_done", 64'(ic_ar_valid_o), 64'd0);
    check("r_ready", 64'(ic_r_ready_o), 64'd1);
    if (v.kind == K_REDIR_WAIT) begin
      redirect_valid_i = 1'b1;
      redirect_pc_i    = v.target;
      @(negedge clk);
      redirect_valid_i = 1'b0;
      check("drop_r_ready", 64'(ic_r_ready_o), 64'd1);
    end
    repeat (v.lat) @(negedge clk);
    ic_r_valid_i = 1'b1;
    ic_r_data_i  = v.data;
    ic_r_resp_i  = v.resp;
    @(negedge clk);
    ic_r_valid_i = 1'b0;
    ic_r_data_i  = '0;
    ic_r_resp_i  = 2'b00;
    case (v.kind)
      K_NORM: begin
        e.pc    = v.addr;
        e.inst  = v.inst;
        e.fault = v.fault;
        sb.push_back(e);
        check("latency_valid", 64'(id_valid_o), 64'd1);
        consume(v.hold);
      end
      K_REDIR_OUT: begin
        check("out_valid", 64'(id_valid_o), 64'd1);
        redirect_valid_i = 1'b1;
        redirect_pc_i    = v.target;
        #1;
        check("redir_mask", 64'(id_valid_o), 64'd0);
        @(negedge clk);
        redirect_valid_i = 1'b0;
        check("redir_out_valid", 64'(id_valid_o), 64'd0);
        check("redir_out_addr", ic_ar_addr_o, tgt);
      end
      default: begin
        check("drop_no_valid", 64'(id_valid_o), 64'd0);
        check("drop_next_addr", ic_ar_addr_o, tgt);
      end
    endcase
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, expected finish by 200000");
    $fatal(1);
  end

  initial begin
    vec_t last;
    n_tests = 0;
    n_fail  = 0;
    vecs[0]  = '{K_NORM, 64'h8000_0000, 0, 1,
                 64'h00000013_00100093, 2'b00, 64'h0, 0,
                 32'h00100093, 1'b0};
    vecs[1]  = '{K_NORM, 64'h8000_0004, 2, 2,
                 64'h00000013_00100093, 2'b00, 64'h0, 5,
                 32'h00000013, 1'b0};
    vecs[2]  = '{K_REDIR_AR, 64'h8000_0008, 0, 1,
                 64'h11111111_22222222, 2'b00, 64'h8000_0040, 0,
                 32'h0, 1'b0};
    vecs[3]  = '{K_NORM, 64'h8000_0040, 0, 0,
                 64'haaaa0001_bbbb0002, 2'b00, 64'h0, 0,
                 32'hbbbb0002, 1'b0};
    vecs[4]  = '{K_REDIR_WAIT, 64'h8000_0044, 0, 0,
                 64'h33333333_44444444, 2'b00, 64'h8000_1002, 0,
                 32'h0, 1'b0};
    vecs[5]  = '{K_NORM, 64'h8000_1000, 0, 3,
                 64'h00008067_00500113, 2'b00, 64'h0, 0,
                 32'h00500113, 1'b0};
    vecs[6]  = '{K_NORM, 64'h8000_1004, 0, 1,
                 64'h12345678_9abcdef0, 2'b10, 64'h0, 2,
                 32'h0, 1'b1};
    vecs[7]  = '{K_NORM, 64'h8000_1008, 1, 0,
                 64'h76543210_0fedcba9, 2'b00, 64'h0, 0,
                 32'h0fedcba9, 1'b0};
    vecs[8]  = '{K_REDIR_OUT, 64'h8000_100c, 0, 1,
                 64'h55555555_66666666, 2'b00,
                 64'hffff_ffff_ffff_ffff, 0, 32'h0, 1'b0};
    vecs[9]  = '{K_NORM, 64'hffff_ffff_ffff_fffc, 0, 1,
                 64'hdeadbeef_00000000, 2'b00, 64'h0, 0,
                 32'hdeadbeef, 1'b0};
    vecs[10] = '{K_NORM, 64'h0, 0, 1,
                 64'h0000abcd_00000093, 2'b00, 64'h0, 0,
                 32'h00000093, 1'b0};
    vecs[11] = '{K_NORM, 64'h4, 0, 0,
                 64'h00a00513_00000093, 2'b00, 64'h0, 0,
                 32'h00a00513, 1'b0};
    last     = '{K_NORM, BOOT_PC, 0, 2,
                 64'h00000013_00100073, 2'b00, 64'h0, 0,
                 32'h00100073, 1'b0};

    rst              = 1'b1;
    redirect_valid_i = 1'b0;
    redirect_pc_i    = '0;
    ic_ar_ready_i    = 1'b0;
    ic_r_valid_i     = 1'b0;
    ic_r_resp_i      = 2'b00;
    ic_r_data_i      = '0;
    id_ready_i       = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_ar_valid", 64'(ic_ar_valid_o), 64'd0);
    check("rst_r_ready", 64'(ic_r_ready_o), 64'd0);
    check("rst_id_valid", 64'(id_valid_o), 64'd0);
    check("rst_id_pc", id_pc_o, 64'd0);
    check("rst_id_inst", 64'(id_inst_o), 64'd0);
    check("rst_id_fault", 64'(id_fault_o), 64'd0);
    rst = 1'b0;
    #1;
    check("boot_no_ar", 64'(ic_ar_valid_o), 64'd0);
    @(negedge clk);
    check("boot_ar_valid", 64'(ic_ar_valid_o), 64'd1);
    check("boot_ar_addr", ic_ar_addr_o, BOOT_PC);

    for (int i = 0; i < 12; i++) begin
      run_row(vecs[i]);
    end

    wait_ar(64'h8);
    ic_ar_ready_i = 1'b1;
    @(negedge clk);
    ic_ar_ready_i = 1'b0;
    check("mid_wait_r_ready", 64'(ic_r_ready_o), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_ar_valid", 64'(ic_ar_valid_o), 64'd0);
    check("mid_rst_r_ready", 64'(ic_r_ready_o), 64'd0);
    check("mid_rst_id_valid", 64'(id_valid_o), 64'd0);
    check("mid_rst_id_pc", id_pc_o, 64'd0);
    check("mid_rst_id_inst", 64'(id_inst_o), 64'd0);
    check("mid_rst_id_fault", 64'(id_fault_o), 64'd0);
    rst = 1'b0;
    #1;
    check("reboot_no_ar", 64'(ic_ar_valid_o), 64'd0);
    @(negedge clk);
    check("reboot_ar_valid", 64'(ic_ar_valid_o), 64'd1);
    check("reboot_ar_addr", ic_ar_addr_o, BOOT_PC);
    run_row(last);
    check("sb_drained", 64'(sb.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ysyx_22050019_ifu.md
Name: ysyx_22050019_ifu

Overview:
- Instruction fetch unit that sits directly upstream of the icache's CPU-side AR/R port.
- Holds the PC and issues one fetch per instruction to the icache.
- Extracts the 32-bit instruction from the returned 64-bit word and hands it to the IDU over a valid/ready handshake.
- Handles redirects (branch, jump, trap) at any point, discarding wrong-path responses so the icache handshake is never broken.

Parameters:
- ADDR_WIDTH, 64, icache request address width.
- DATA_WIDTH, 64, icache response data width.
- INST_WIDTH, 32, instruction width.
- RESET_PC, 64'h0000_0000_8000_0000, first fetch address after reset.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- redirect_valid_i  in  1  redirect request from execute/commit
- redirect_pc_i  in  ADDR_WIDTH  redirect target; bits [1:0] ignored (forced to 0)
- ic_ar_valid_o  out  1  fetch request valid
- ic_ar_ready_i  in  1  icache accepts request
- ic_ar_addr_o  out  ADDR_WIDTH  fetch address, always equal to the PC register
- ic_r_valid_i  in  1  icache data valid
- ic_r_ready_o  out  1  IFU accepts data
- ic_r_resp_i  in  2  response code; nonzero means error
- ic_r_data_i  in  DATA_WIDTH  64-bit aligned fetch word
- id_valid_o  out  1  instruction valid to IDU
- id_ready_i  in  1  IDU accepts instruction
- id_pc_o  out  ADDR_WIDTH  PC of the presented instruction
- id_inst_o  out  INST_WIDTH  instruction
- id_fault_o  out  1  fetch access fault flag

Behaviour:
- Clock and reset: one clock. Reset is synchronous and active-high.
- Reset values:
  - state = S_BOOT, pc = RESET_PC.
  - ic_ar_valid_o = 0, ic_r_ready_o = 0, id_valid_o = 0.
  - id_pc_o = 0, id_inst_o = 0, id_fault_o = 0.
- States:
  - S_BOOT: go to S_REQ unconditionally. The first ic_ar_valid_o rises 1 cycle after reset deasserts.
  - S_REQ: ic_ar_valid_o = 1, address = pc.
    - On ar handshake, go to S_WAIT.
    - ar_valid must not drop before the handshake; only a redirect may change the address.
  - S_WAIT: ic_r_ready_o = 1. On r handshake:
    - Capture id_pc_o = pc.
    - id_inst_o = pc[2] ? data[63:32] : data[31:0].
    - id_fault_o = (resp != 0). If the fault is set, id_inst_o = 0.
    - Go to S_OUT.
  - S_OUT: id_valid_o = state==S_OUT & ~redirect_valid_i.
    - On id handshake: pc <= pc + 4 (wraps modulo 2^ADDR_WIDTH), go to S_REQ.
    - Outputs stay stable while id_ready_i = 0.
  - S_DROP: ic_r_ready_o = 1. On r handshake, discard the data and go to S_REQ.
- Redirect handling (redirect has highest priority in every state):
  - pc <= {redirect_pc_i[63:2], 2'b00}.
  - S_REQ without handshake: stay in S_REQ. The address changes the next cycle; ar_valid stays high.
  - S_REQ with ar handshake in the same cycle: the old request is in flight, so go to S_DROP.
  - S_WAIT with r handshake in the same cycle: discard the data and go to S_REQ.
  - S_WAIT without r handshake: go to S_DROP.
  - S_DROP: stay in S_DROP until the pending response is consumed. The latest redirect PC wins.
  - S_OUT: the held instruction is wrong-path. id_valid_o is masked that cycle; go to S_REQ.
  - S_BOOT: pc is overwritten; go to S_REQ.
- Handshake rules:
  - At most one outstanding icache request.
  - A response is never refused once its request has been accepted.
- Latency and throughput:
  - Latency: icache response latency plus 1 cycle (the capture register) to id_valid_o.
  - Throughput: at most 1 instruction per (icache round trip + 2) cycles. No prefetch.
- Reset during any state: return to S_BOOT next cycle and drop all outstanding handshakes. The icache is reset by the same rst.
- PC arithmetic: full ADDR_WIDTH, unsigned, no overflow detection.

Decomposition:
- Shared package ysyx_22050019_pkg holds:
  - state encodings (S_BOOT, S_REQ, S_WAIT, S_OUT, S_DROP);
  - RESET_PC;
  - INST_WIDTH;
  - the RESP_OKAY = 2'b00 constant.
- No sub-module. The single FSM plus the PC and capture registers make up the block.

Test Plan:
- Reset release, icache answers 0x00000013_00100093 at 0x80000000 → id_pc_o = 0x80000000, id_inst_o = 0x00100093. After id_ready_i, the next ic_ar_addr_o = 0x80000004 and id_inst_o = 0x00000013.
- id_ready_i held low for 5 cycles in S_OUT → id_valid_o, id_pc_o and id_inst_o stay stable, and no new ic_ar_valid_o is issued.
- Redirect to 0x80001002 in S_WAIT one cycle before ic_r_valid_i → the response is consumed and not presented. The next request address is 0x80001000, and only its instruction reaches the IDU.
- Redirect in S_REQ in the same cycle as the ar handshake for 0x80000008 → state goes to S_DROP, the 0x80000008 data is discarded, and the next request uses the redirect PC.
- ic_r_resp_i = 2'b10 → id_fault_o = 1 and id_inst_o = 0. The next fetch uses pc + 4 after the id handshake.
- pc = 0xFFFFFFFF_FFFFFFFC, then id handshake → the next ic_ar_addr_o is 0. Asserting rst mid-S_WAIT → all outputs return to 0 and the first request after release is at RESET_PC.
